// File: rtl/wb_commit_unit_pkg.sv
// Shared constants and entry layout for the write-back commit unit.
package wb_commit_unit_pkg;

  localparam int WB_XLEN   = 32;
  localparam int WB_REG_AW = 5;
  localparam int WB_DEPTH  = 4;

  // A buffered commit is {rd, data}; data occupies the low bits.
  localparam int WB_ENTRY_W   = WB_REG_AW + WB_XLEN;
  localparam int WB_DATA_LSB  = 0;
  localparam int WB_DATA_MSB  = WB_XLEN - 1;
  localparam int WB_RD_LSB    = WB_XLEN;
  localparam int WB_RD_MSB    = WB_XLEN + WB_REG_AW - 1;

  typedef struct packed {
    logic [WB_REG_AW-1:0] rd;
    logic [WB_XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Single-clock synchronous FIFO holding pending register-file commits.
module wb_fifo
  import wb_commit_unit_pkg::*;
#(
  parameter int WIDTH = WB_ENTRY_W,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Guard push/pop against full/empty so the occupancy can never wrap.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next-state: write at the tail, advance pointers, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO and discards its contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Register-file writer: arbitrates LSU/ALU results into a commit FIFO,
// drives one write per cycle and keeps a per-register busy scoreboard.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int XLEN   = WB_XLEN,
  parameter int REG_AW = WB_REG_AW,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              lsu_ready,
  input  logic              wb_hold,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [31:0]       busy_mask,
  output logic              fifo_full,
  output logic              fifo_empty
);

  localparam int ENTRY_W = REG_AW + XLEN;
  localparam int AW      = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [AW:0]        fifo_count;
  logic               push;
  logic               pop;
  logic [REG_AW-1:0]  head_rd;
  logic [XLEN-1:0]    head_data;
  logic [31:0]        busy_q, busy_d;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_rd   = head_entry[XLEN +: REG_AW];
  assign head_data = head_entry[XLEN-1:0];

  // Ready comes only from registered occupancy and lsu_valid (LSU has priority).
  assign lsu_ready = (fifo_count != FULL_COUNT);
  assign alu_ready = lsu_ready & ~lsu_valid;

  // Select the accepted producer; results for x0 complete but are not buffered.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (lsu_valid && lsu_ready) begin
      push_entry = {lsu_rd, lsu_data};
      push       = (lsu_rd != '0);
    end else if (alu_valid && alu_ready) begin
      push_entry = {alu_rd, alu_data};
      push       = (alu_rd != '0);
    end
  end

  // Commit the FIFO head unless halted; nothing is written in a reset cycle.
  always_comb begin
    pop      = ~fifo_empty & ~wb_hold & ~reset;
    rf_we    = pop;
    rf_waddr = pop ? head_rd : '0;
    rf_wdata = pop ? head_data : '0;
  end

  // Scoreboard next-state: commit clears, a new issue sets (and wins), x0 stays 0.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_mask = busy_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: a queue scoreboard predicts every
// commit, ready, flag and busy bit, plus directed checks for the key scenarios.
module tb_wb_commit_unit;
  import wb_commit_unit_pkg::*;

  localparam int XLEN   = WB_XLEN;
  localparam int REG_AW = WB_REG_AW;
  localparam int DEPTH  = WB_DEPTH;

  logic              clk;
  logic              reset;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_ready;
  logic              lsu_valid;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              lsu_ready;
  logic              wb_hold;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [31:0]       busy_mask;
  logic              fifo_full;
  logic              fifo_empty;

  int total = 0;
  int bad   = 0;

  wb_entry_t   expQ[$];
  logic [31:0] modelBusy = '0;

  wb_commit_unit #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .wb_hold     (wb_hold),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy_mask   (busy_mask),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive the ALU producer interface.
  task automatic applyStimulus(input logic v, input logic [REG_AW-1:0] rd,
                               input logic [XLEN-1:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  // Bounded wait for the commit FIFO to drain.
  task automatic waitEmpty(input string tag);
    for (int k = 0; k < 40 && !fifo_empty; k++) tick;
    checkOutput(tag, 64'(fifo_empty), 64'd1);
  endtask

  // Reference model: accept, buffer, commit and scoreboard at each rising edge.
  always @(posedge clk) begin : model
    int          depthNow;
    logic        lsuTake;
    logic        aluTake;
    wb_entry_t   head;
    logic [31:0] nextBusy;
    if (reset) begin
      expQ.delete();
      modelBusy <= '0;
    end else begin
      depthNow = expQ.size();
      lsuTake  = lsu_valid && (depthNow < DEPTH);
      aluTake  = alu_valid && !lsu_valid && (depthNow < DEPTH);
      nextBusy = modelBusy;
      if (depthNow > 0 && !wb_hold) begin
        head = expQ.pop_front();
        nextBusy[head.rd] = 1'b0;
      end
      if (lsuTake && lsu_rd != '0) expQ.push_back({lsu_rd, lsu_data});
      else if (aluTake && alu_rd != '0) expQ.push_back({alu_rd, alu_data});
      if (issue_valid && issue_rd != '0) nextBusy[issue_rd] = 1'b1;
      nextBusy[0] = 1'b0;
      modelBusy <= nextBusy;
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin : monitor
    int   depthNow;
    logic expWe;
    depthNow = expQ.size();
    expWe    = (depthNow > 0) && !wb_hold && !reset;
    checkOutput("rf_we", 64'(rf_we), 64'(expWe));
    if (expWe) begin
      checkOutput("rf_waddr", 64'(rf_waddr), 64'(expQ[0].rd));
      checkOutput("rf_wdata", 64'(rf_wdata), 64'(expQ[0].data));
    end else begin
      checkOutput("rf_waddr_idle", 64'(rf_waddr), 64'd0);
      checkOutput("rf_wdata_idle", 64'(rf_wdata), 64'd0);
    end
    checkOutput("busy_mask", 64'(busy_mask), 64'(modelBusy));
    checkOutput("fifo_empty", 64'(fifo_empty), 64'(depthNow == 0));
    checkOutput("fifo_full", 64'(fifo_full), 64'(depthNow == DEPTH));
    checkOutput("lsu_ready", 64'(lsu_ready), 64'(depthNow < DEPTH));
    checkOutput("alu_ready", 64'(alu_ready), 64'((depthNow < DEPTH) && !lsu_valid));
  end

  // Directed scenarios followed by a constrained-random phase.
  initial begin : stimulus
    logic lsuPend;
    logic aluPend;
    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_rd    = '0;
    lsu_valid   = 1'b0;
    lsu_rd      = '0;
    lsu_data    = '0;
    wb_hold     = 1'b0;
    applyStimulus(1'b0, '0, '0);
    tick;
    tick;
    checkOutput("rst_empty", 64'(fifo_empty), 64'd1);
    checkOutput("rst_full", 64'(fifo_full), 64'd0);
    checkOutput("rst_we", 64'(rf_we), 64'd0);
    checkOutput("rst_busy", 64'(busy_mask), 64'd0);
    reset = 1'b0;
    tick;

    // Single ALU result with a pending x5.
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    tick;
    issue_valid = 1'b0;
    checkOutput("t1_busy5_set", 64'(busy_mask[5]), 64'd1);
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    checkOutput("t1_alu_ready", 64'(alu_ready), 64'd1);
    checkOutput("t1_no_early_we", 64'(rf_we), 64'd0);
    tick;
    applyStimulus(1'b0, '0, '0);
    #1;
    checkOutput("t1_we", 64'(rf_we), 64'd1);
    checkOutput("t1_waddr", 64'(rf_waddr), 64'd5);
    checkOutput("t1_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    tick;
    checkOutput("t1_we_once", 64'(rf_we), 64'd0);
    checkOutput("t1_busy5_clr", 64'(busy_mask[5]), 64'd0);

    // LSU and ALU contend; LSU wins, ALU follows.
    lsu_valid = 1'b1;
    lsu_rd    = 5'd3;
    lsu_data  = 32'h11;
    applyStimulus(1'b1, 5'd4, 32'h22);
    #1;
    checkOutput("t2_lsu_ready", 64'(lsu_ready), 64'd1);
    checkOutput("t2_alu_blocked", 64'(alu_ready), 64'd0);
    tick;
    lsu_valid = 1'b0;
    #1;
    checkOutput("t2_alu_ready", 64'(alu_ready), 64'd1);
    checkOutput("t2_first_addr", 64'(rf_waddr), 64'd3);
    checkOutput("t2_first_data", 64'(rf_wdata), 64'h11);
    tick;
    applyStimulus(1'b0, '0, '0);
    #1;
    checkOutput("t2_second_addr", 64'(rf_waddr), 64'd4);
    checkOutput("t2_second_data", 64'(rf_wdata), 64'h22);
    tick;

    // Fill under hold, then release and drain in order.
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i));
      tick;
    end
    applyStimulus(1'b1, 5'd9, 32'h999);
    #1;
    checkOutput("t3_full", 64'(fifo_full), 64'd1);
    checkOutput("t3_alu_stall", 64'(alu_ready), 64'd0);
    checkOutput("t3_hold_no_we", 64'(rf_we), 64'd0);
    tick;
    wb_hold = 1'b0;
    #1;
    checkOutput("t3_pop1_addr", 64'(rf_waddr), 64'd1);
    checkOutput("t3_ready_still_low", 64'(alu_ready), 64'd0);
    tick;
    checkOutput("t3_ready_back", 64'(alu_ready), 64'd1);
    checkOutput("t3_pop2_addr", 64'(rf_waddr), 64'd2);
    tick;
    applyStimulus(1'b0, '0, '0);
    waitEmpty("t3_drain");

    // Write to x0 handshakes but is never committed.
    applyStimulus(1'b1, 5'd0, 32'h1234);
    #1;
    checkOutput("t4_alu_ready", 64'(alu_ready), 64'd1);
    tick;
    applyStimulus(1'b0, '0, '0);
    #1;
    checkOutput("t4_empty", 64'(fifo_empty), 64'd1);
    checkOutput("t4_no_we", 64'(rf_we), 64'd0);
    tick;

    // Re-issue of x7 on the same edge as its commit keeps it busy.
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    applyStimulus(1'b1, 5'd7, 32'hA7);
    tick;
    applyStimulus(1'b0, '0, '0);
    #1;
    checkOutput("t5_commit7", 64'(rf_waddr), 64'd7);
    tick;
    issue_valid = 1'b0;
    checkOutput("t5_busy7_kept", 64'(busy_mask[7]), 64'd1);
    applyStimulus(1'b1, 5'd7, 32'hB7);
    tick;
    applyStimulus(1'b0, '0, '0);
    tick;
    checkOutput("t5_busy7_clr", 64'(busy_mask[7]), 64'd0);

    // Reset while entries are buffered discards them.
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1;
      issue_rd    = 5'(10 + i);
      applyStimulus(1'b1, 5'(10 + i), 32'hC0 + 32'(i));
      tick;
    end
    issue_valid = 1'b0;
    applyStimulus(1'b0, '0, '0);
    checkOutput("t6_buffered", 64'(fifo_empty), 64'd0);
    checkOutput("t6_busy_set", 64'(busy_mask[12:10]), 64'h7);
    reset   = 1'b1;
    wb_hold = 1'b0;
    #1;
    checkOutput("t6_no_we_in_reset", 64'(rf_we), 64'd0);
    tick;
    reset = 1'b0;
    checkOutput("t6_empty", 64'(fifo_empty), 64'd1);
    checkOutput("t6_busy_clr", 64'(busy_mask), 64'd0);
    checkOutput("t6_no_we", 64'(rf_we), 64'd0);
    repeat (3) tick;

    // Random traffic; producers hold their request until it is accepted.
    lsuPend = 1'b0;
    aluPend = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (!lsuPend) begin
        lsu_valid = ($urandom_range(0, 2) == 0);
        lsu_rd    = 5'($urandom_range(0, 31));
        lsu_data  = $urandom;
      end
      if (!aluPend) begin
        applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 31));
      wb_hold     = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      lsuPend = lsu_valid && !lsu_ready;
      aluPend = alu_valid && !alu_ready;
      tick;
    end
    lsu_valid   = 1'b0;
    issue_valid = 1'b0;
    wb_hold     = 1'b0;
    applyStimulus(1'b0, '0, '0);
    waitEmpty("rand_drain");
    tick;
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
